// File: rtl/lcd_cmd_fsm.sv
// Panel reset, init hand-off and cursor-tracking PIXEL/FILL command engine for HX8352-style TFTs.
// Optional build macro LCD_TE_SYNC_EN: FILL data waits for a synchronised rising edge of lcd_te.
module lcd_cmd_fsm #(
    parameter int         DATA_W       = 16,
    parameter int         X_W          = 9,
    parameter int         Y_W          = 9,
    parameter int         X_MAX        = 239,
    parameter int         Y_MAX        = 399,
    parameter int         CNT_W        = 17,
    parameter int         RST_LOW_CYC  = 50,
    parameter int         RST_WAIT_CYC = 60,
    parameter logic [7:0] REG_XH       = 8'h02,
    parameter logic [7:0] REG_XL       = 8'h03,
    parameter logic [7:0] REG_YH       = 8'h06,
    parameter logic [7:0] REG_YL       = 8'h07,
    parameter logic [7:0] REG_WR       = 8'h22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              init_start,
    input  logic              init_done,
    output logic              init_active,
    output logic              bus_step,
    output logic              bus_rs,
    output logic [DATA_W-1:0] bus_data,
    input  logic              bus_done,
    output logic              delay_step,
    output logic [15:0]       delay_value,
    input  logic              delay_done,
`ifdef LCD_TE_SYNC_EN
    input  logic              lcd_te,
`endif
    output logic              lcd_cs,
    output logic              lcd_rst,
    output logic              busy,
    output logic              err,
    output logic [X_W-1:0]    cur_x,
    output logic [Y_W-1:0]    cur_y
);

    localparam logic [2:0]  OP_NOP   = 3'd0;
    localparam logic [2:0]  OP_HOME  = 3'd1;
    localparam logic [2:0]  OP_SETX  = 3'd2;
    localparam logic [2:0]  OP_SETY  = 3'd3;
    localparam logic [2:0]  OP_SETXY = 3'd4;
    localparam logic [2:0]  OP_PIXEL = 3'd5;
    localparam logic [2:0]  OP_FILL  = 3'd6;
    localparam logic [31:0] X_LAST   = 32'(X_MAX);
    localparam logic [31:0] Y_LAST   = 32'(Y_MAX);

    typedef enum logic [3:0] {
        RST_LO, RST_WAIT, RST_REL, INIT, IDLE, EXEC,
        CURSOR, WRCMD, TE_WAIT, PIX, PIX_END
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [2:0]          step_q, step_d;
    logic                wait_q, wait_d;
    logic                dirty_q, dirty_d;
    logic                err_q, err_d;
    logic [X_W-1:0]      cur_x_q, cur_x_d;
    logic [Y_W-1:0]      cur_y_q, cur_y_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                init_start_q, init_start_d;
    logic                init_active_q, init_active_d;
    logic                bus_step_q, bus_step_d;
    logic                bus_rs_q, bus_rs_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic                delay_step_q, delay_step_d;
    logic [15:0]         delay_value_q, delay_value_d;
    logic                lcd_cs_q, lcd_cs_d;
    logic                lcd_rst_q, lcd_rst_d;

    logic                go_idle;
    logic                start_burst;
    logic                done_ok;
    logic                dly_ok;
    logic [15:0]         x_ext;
    logic [15:0]         y_ext;
    logic [7:0]          reg_byte;

`ifdef LCD_TE_SYNC_EN
    // te_q[1:0] synchronise, te_q[2] holds the previous synchronised level
    logic [2:0] te_q;
    logic       te_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) te_q <= '0;
        else     te_q <= {te_q[1:0], lcd_te};
    end

    assign te_rise = te_q[1] & ~te_q[2];
`endif

    // A completion arriving while our own request is still high belongs to nothing we issued.
    assign done_ok = bus_done & ~bus_step_q;
    assign dly_ok  = delay_done & ~delay_step_q;

    assign x_ext = 16'(cur_x_q);
    assign y_ext = 16'(cur_y_q);

    always_comb begin
        reg_byte = y_ext[7:0];
        case (step_q)
            3'd0:    reg_byte = REG_XH;
            3'd1:    reg_byte = x_ext[15:8];
            3'd2:    reg_byte = REG_XL;
            3'd3:    reg_byte = x_ext[7:0];
            3'd4:    reg_byte = REG_YH;
            3'd5:    reg_byte = y_ext[15:8];
            3'd6:    reg_byte = REG_YL;
            default: reg_byte = y_ext[7:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        x_d           = x_q;
        y_d           = y_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        step_d        = step_q;
        wait_d        = wait_q;
        dirty_d       = dirty_q;
        err_d         = err_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        cmd_ready_d   = cmd_ready_q;
        busy_d        = busy_q;
        init_active_d = init_active_q;
        bus_rs_d      = bus_rs_q;
        bus_data_d    = bus_data_q;
        delay_value_d = delay_value_q;
        lcd_cs_d      = lcd_cs_q;
        lcd_rst_d     = lcd_rst_q;
        init_start_d  = 1'b0;
        bus_step_d    = 1'b0;
        delay_step_d  = 1'b0;
        go_idle       = 1'b0;
        start_burst   = 1'b0;

        case (state_q)
            RST_LO: begin
                lcd_rst_d     = 1'b0;
                delay_step_d  = 1'b1;
                delay_value_d = 16'(RST_LOW_CYC);
                state_d       = RST_WAIT;
            end
            RST_WAIT: begin
                if (dly_ok) begin
                    lcd_rst_d     = 1'b1;
                    delay_step_d  = 1'b1;
                    delay_value_d = 16'(RST_WAIT_CYC);
                    state_d       = RST_REL;
                end
            end
            RST_REL: begin
                if (dly_ok) begin
                    lcd_cs_d      = 1'b0;
                    init_start_d  = 1'b1;
                    init_active_d = 1'b1;
                    state_d       = INIT;
                end
            end
            INIT: begin
                if (init_done && !init_start_q) begin
                    init_active_d = 1'b0;
                    go_idle       = 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    x_d         = cmd_x;
                    y_d         = cmd_y;
                    data_d      = cmd_data;
                    cnt_d       = cmd_count;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                go_idle = 1'b1;
                case (op_q)
                    OP_NOP: ;
                    OP_HOME: begin
                        cur_x_d = '0;
                        cur_y_d = '0;
                        dirty_d = 1'b1;
                    end
                    OP_SETX: begin
                        if (32'(x_q) > X_LAST) err_d = 1'b1;
                        else begin
                            cur_x_d = x_q;
                            dirty_d = 1'b1;
                        end
                    end
                    OP_SETY: begin
                        if (32'(y_q) > Y_LAST) err_d = 1'b1;
                        else begin
                            cur_y_d = y_q;
                            dirty_d = 1'b1;
                        end
                    end
                    OP_SETXY: begin
                        if (32'(x_q) > X_LAST || 32'(y_q) > Y_LAST) err_d = 1'b1;
                        else begin
                            cur_x_d = x_q;
                            cur_y_d = y_q;
                            dirty_d = 1'b1;
                        end
                    end
                    OP_PIXEL: begin
                        rem_d       = CNT_W'(1);
                        go_idle     = 1'b0;
                        start_burst = 1'b1;
                    end
                    OP_FILL: begin
                        if (cnt_q != '0) begin
                            rem_d       = cnt_q;
                            go_idle     = 1'b0;
                            start_burst = 1'b1;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
            CURSOR: begin
                // Eight transactions: index/data pairs for XH, XL, YH, YL.
                if (!wait_q) begin
                    bus_step_d = 1'b1;
                    bus_rs_d   = step_q[0];
                    bus_data_d = DATA_W'(reg_byte);
                    wait_d     = 1'b1;
                end else if (done_ok) begin
                    wait_d = 1'b0;
                    if (step_q == 3'd7) begin
                        dirty_d = 1'b0;
                        state_d = WRCMD;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            WRCMD: begin
                if (!wait_q) begin
                    bus_step_d = 1'b1;
                    bus_rs_d   = 1'b0;
                    bus_data_d = DATA_W'(REG_WR);
                    wait_d     = 1'b1;
                end else if (done_ok) begin
                    wait_d  = 1'b0;
                    state_d = PIX;
`ifdef LCD_TE_SYNC_EN
                    if (op_q == OP_FILL) state_d = TE_WAIT;
`endif
                end
            end
`ifdef LCD_TE_SYNC_EN
            TE_WAIT: begin
                if (te_rise) state_d = PIX;
            end
`endif
            PIX: begin
                if (!wait_q) begin
                    bus_step_d = 1'b1;
                    bus_rs_d   = 1'b1;
                    bus_data_d = data_q;
                    wait_d     = 1'b1;
                end else if (done_ok) begin
                    wait_d = 1'b0;
                    rem_d  = rem_q - CNT_W'(1);
                    if (32'(cur_x_q) == X_LAST) begin
                        cur_x_d = '0;
                        cur_y_d = (32'(cur_y_q) == Y_LAST) ? '0 : cur_y_q + Y_W'(1);
                    end else begin
                        cur_x_d = cur_x_q + X_W'(1);
                    end
                    if (rem_q == CNT_W'(1)) state_d = PIX_END;
                end
            end
            PIX_END: go_idle = 1'b1;
            default: state_d = RST_LO;
        endcase

        if (start_burst) begin
            lcd_cs_d = 1'b0;
            wait_d   = 1'b0;
            step_d   = '0;
            state_d  = dirty_q ? CURSOR : WRCMD;
        end
        if (go_idle) begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            lcd_cs_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RST_LO;
            op_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
            step_q        <= '0;
            wait_q        <= 1'b0;
            dirty_q       <= 1'b1;
            err_q         <= 1'b0;
            cur_x_q       <= '0;
            cur_y_q       <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            init_start_q  <= 1'b0;
            init_active_q <= 1'b0;
            bus_step_q    <= 1'b0;
            bus_rs_q      <= 1'b0;
            bus_data_q    <= '0;
            delay_step_q  <= 1'b0;
            delay_value_q <= '0;
            lcd_cs_q      <= 1'b1;
            lcd_rst_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            x_q           <= x_d;
            y_q           <= y_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            step_q        <= step_d;
            wait_q        <= wait_d;
            dirty_q       <= dirty_d;
            err_q         <= err_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            init_start_q  <= init_start_d;
            init_active_q <= init_active_d;
            bus_step_q    <= bus_step_d;
            bus_rs_q      <= bus_rs_d;
            bus_data_q    <= bus_data_d;
            delay_step_q  <= delay_step_d;
            delay_value_q <= delay_value_d;
            lcd_cs_q      <= lcd_cs_d;
            lcd_rst_q     <= lcd_rst_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign cur_x       = cur_x_q;
    assign cur_y       = cur_y_q;
    assign init_start  = init_start_q;
    assign init_active = init_active_q;
    assign bus_step    = bus_step_q;
    assign bus_rs      = bus_rs_q;
    assign bus_data    = bus_data_q;
    assign delay_step  = delay_step_q;
    assign delay_value = delay_value_q;
    assign lcd_cs      = lcd_cs_q;
    assign lcd_rst     = lcd_rst_q;

endmodule

// File: tb/tb_lcd_cmd_fsm.sv
// Bench for lcd_cmd_fsm: scoreboard of expected bus transactions fed by a linear-address cursor model.
`timescale 1ns/1ps
module tb_lcd_cmd_fsm;
    localparam int X_W   = 9;
    localparam int Y_W   = 9;
    localparam int X_MAX = 239;
    localparam int Y_MAX = 399;
    localparam int CNT_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [X_W-1:0]    cmd_x = '0;
    logic [Y_W-1:0]    cmd_y = '0;
    logic [15:0]       cmd_data = '0;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic              init_start;
    logic              init_done = 1'b0;
    logic              init_active;
    logic              bus_step;
    logic              bus_rs;
    logic [15:0]       bus_data;
    logic              bus_done = 1'b0;
    logic              delay_step;
    logic [15:0]       delay_value;
    logic              delay_done = 1'b0;
    logic              lcd_cs;
    logic              lcd_rst;
    logic              busy;
    logic              err;
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
`ifdef LCD_TE_SYNC_EN
    logic              lcd_te = 1'b0;
`endif

    lcd_cmd_fsm dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .init_start(init_start), .init_done(init_done), .init_active(init_active),
        .bus_step(bus_step), .bus_rs(bus_rs), .bus_data(bus_data), .bus_done(bus_done),
        .delay_step(delay_step), .delay_value(delay_value), .delay_done(delay_done),
`ifdef LCD_TE_SYNC_EN
        .lcd_te(lcd_te),
`endif
        .lcd_cs(lcd_cs), .lcd_rst(lcd_rst), .busy(busy), .err(err),
        .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic rs; logic [15:0] d; } txn_t;
    txn_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    int   m_x, m_y;
    bit   m_dirty, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [15:0] d);
        txn_t t;
        t.rs = rs;
        t.d  = d;
        exp_q.push_back(t);
    endtask

    // Reference model: cursor as a linear pixel address in a (X_MAX+1) x (Y_MAX+1) frame.
    task automatic model_cmd(input logic [2:0] op, input int x, input int y,
                             input logic [15:0] d, input int n);
        int cnt, pos;
        case (op)
            3'd1: begin m_x = 0; m_y = 0; m_dirty = 1; end
            3'd2: if (x > X_MAX) m_err = 1; else begin m_x = x; m_dirty = 1; end
            3'd3: if (y > Y_MAX) m_err = 1; else begin m_y = y; m_dirty = 1; end
            3'd4: if (x > X_MAX || y > Y_MAX) m_err = 1;
                  else begin m_x = x; m_y = y; m_dirty = 1; end
            3'd5, 3'd6: begin
                cnt = (op == 3'd5) ? 1 : n;
                if (cnt > 0) begin
                    if (m_dirty) begin
                        push(0, 16'h0002); push(1, 16'(m_x / 256));
                        push(0, 16'h0003); push(1, 16'(m_x % 256));
                        push(0, 16'h0006); push(1, 16'(m_y / 256));
                        push(0, 16'h0007); push(1, 16'(m_y % 256));
                        m_dirty = 0;
                    end
                    push(0, 16'h0022);
                    for (int i = 0; i < cnt; i++) begin
                        push(1, d);
                        pos = (m_y * (X_MAX + 1) + m_x + 1) % ((X_MAX + 1) * (Y_MAX + 1));
                        m_x = pos % (X_MAX + 1);
                        m_y = pos / (X_MAX + 1);
                    end
                end
            end
            3'd7: m_err = 1;
            default: ;
        endcase
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_lcd_cs"},      32'(lcd_cs), 1);
        check({p, "_lcd_rst"},     32'(lcd_rst), 1);
        check({p, "_bus_step"},    32'(bus_step), 0);
        check({p, "_bus_rs"},      32'(bus_rs), 0);
        check({p, "_bus_data"},    32'(bus_data), 0);
        check({p, "_delay_step"},  32'(delay_step), 0);
        check({p, "_delay_value"}, 32'(delay_value), 0);
        check({p, "_cmd_ready"},   32'(cmd_ready), 0);
        check({p, "_init_start"},  32'(init_start), 0);
        check({p, "_init_active"}, 32'(init_active), 0);
        check({p, "_busy"},        32'(busy), 1);
        check({p, "_err"},         32'(err), 0);
        check({p, "_cur_x"},       32'(cur_x), 0);
        check({p, "_cur_y"},       32'(cur_y), 0);
    endtask

    task automatic wait_sig(input string name, input int which, input int limit);
        int t = 0;
        bit s = 0;
        while (t < limit) begin
            case (which)
                0: s = delay_step;
                1: s = init_start;
                default: s = cmd_ready;
            endcase
            if (s) break;
            @(negedge clk);
            t++;
        end
        check({name, "_seen"}, 32'(s), 1);
    endtask

    task automatic reset_seq();
        rst = 1; init_done = 0; delay_done = 0; cmd_valid = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 0;
        wait_sig("rst_lo_delay", 0, 10);
        check("rst_lo_value", 32'(delay_value), 50);
        check("rst_lo_pin", 32'(lcd_rst), 0);
        @(negedge clk);
        check("rst_lo_step_pulse", 32'(delay_step), 0);
        repeat (3) @(negedge clk);
        check("rst_lo_hold", 32'(lcd_rst), 0);
        delay_done = 1; @(negedge clk); delay_done = 0;
        wait_sig("rst_wait_delay", 0, 10);
        check("rst_wait_value", 32'(delay_value), 60);
        check("rst_wait_pin", 32'(lcd_rst), 1);
        repeat (2) @(negedge clk);
        delay_done = 1; @(negedge clk); delay_done = 0;
        wait_sig("init_start", 1, 10);
        check("init_active", 32'(init_active), 1);
        check("init_cs", 32'(lcd_cs), 0);
        @(negedge clk);
        check("init_start_pulse", 32'(init_start), 0);
        repeat (3) begin
            check("init_ready_low", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        init_done = 1;
        wait_sig("init_ready", 2, 10);
        check("idle_busy", 32'(busy), 0);
        check("idle_init_active", 32'(init_active), 0);
        check("idle_cs", 32'(lcd_cs), 1);
        m_x = 0; m_y = 0; m_dirty = 1; m_err = 0;
    endtask

    task automatic send(input logic [2:0] op, input int x, input int y,
                        input logic [15:0] d, input int n, input bit wait_done);
        wait_sig("cmd_ready", 2, 200);
        cmd_valid = 1; cmd_op = op;
        cmd_x = X_W'(x); cmd_y = Y_W'(y); cmd_data = d; cmd_count = CNT_W'(n);
        model_cmd(op, x, y, d, n);
        @(negedge clk);
        cmd_valid = 0;
        check("ready_drop", 32'(cmd_ready), 0);
        if (wait_done) begin
            wait_sig("cmd_complete", 2, 3000);
            check("cur_x", 32'(cur_x), 32'(m_x));
            check("cur_y", 32'(cur_y), 32'(m_y));
            check("err", 32'(err), 32'(m_err));
            check("pending_txns", 32'(exp_q.size()), 0);
        end
    endtask

    // Monitor: every bus request must match the head of the scoreboard.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (bus_step === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_bus_step: got rs=%0d data=%0h, expected no transaction",
                             bus_rs, bus_data);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_txn", {15'b0, bus_rs, bus_data}, {15'b0, e.rs, e.d});
                    check("bus_cs", 32'(lcd_cs), 0);
                end
            end
        end
    end

    // Bus writer model: completes each request after 1..3 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_step === 1'b1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus_done = 1;
                @(negedge clk);
                bus_done = 0;
            end
        end
    end

`ifdef LCD_TE_SYNC_EN
    initial forever begin
        repeat (7) @(negedge clk);
        lcd_te = ~lcd_te;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_seq();
        // Directed scenarios
        send(3'd4, 10, 20, 16'h0000, 0, 1);
        send(3'd5, 0, 0, 16'hF800, 0, 1);
        check("pixel_cur_x_11", 32'(cur_x), 11);
        send(3'd5, 0, 0, 16'h07E0, 0, 1);
        send(3'd2, 239, 0, 16'h0000, 0, 1);
        send(3'd6, 0, 0, 16'h001F, 3, 1);
        check("fill_wrap_x", 32'(cur_x), 2);
        check("fill_wrap_y", 32'(cur_y), 21);
        send(3'd4, 239, 399, 16'h0000, 0, 1);
        send(3'd6, 0, 0, 16'hFFFF, 3, 1);
        check("frame_wrap_y", 32'(cur_y), 0);
        send(3'd6, 0, 0, 16'h1234, 0, 1);
        send(3'd0, 0, 0, 16'h0000, 0, 1);
        send(3'd1, 0, 0, 16'h0000, 0, 1);
        send(3'd2, 240, 0, 16'h0000, 0, 1);
        check("set_x_oor_err", 32'(err), 1);
        send(3'd3, 0, 400, 16'h0000, 0, 1);
        send(3'd7, 0, 0, 16'h0000, 0, 1);

        // Randomised commands
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), int'($urandom_range(0, 260)), int'($urandom_range(0, 420)),
                 16'($urandom), int'($urandom_range(0, 10)), 1);
        end

        // Reset in the middle of a FILL burst
        send(3'd4, 5, 5, 16'h0000, 0, 1);
        send(3'd6, 0, 0, 16'hABCD, 60, 0);
        repeat (60) @(negedge clk);
        check("midfill_busy", 32'(busy), 1);
        #2;
        rst = 1;
        exp_q.delete();
        #1;
        check_reset_vals("midfill");
        reset_seq();
        send(3'd5, 0, 0, 16'h5555, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
